// File: rtl/switch_port_arbiter_pkg.sv
// Shared types and constants for the 4-port switch fabric arbiter.
// Widths here are the fabric defaults; the arbiter derives its own from its parameters.
package switch_pkg;

   localparam int NPORTS = 4;
   localparam int DATA_W = 32;
   localparam int PORT_W = $clog2(NPORTS);

   localparam logic [DATA_W-1:0] EOP_WORD = '0;

   typedef logic [PORT_W-1:0] port_t;
   typedef logic [DATA_W-1:0] word_t;

   typedef enum logic {
      IN_IDLE,
      IN_LOCKED
   } in_state_t;

   typedef enum logic {
      OUT_FREE,
      OUT_BUSY
   } out_state_t;

endpackage

// File: rtl/switch_port_arbiter_if.sv
// Bundle between the input FIFO readers (master) and the port arbiter (slave).
// Head words, ready strobes, forwarded words and ownership/perf reporting.
interface switch_port_arbiter_if #(
   parameter int NPORTS = switch_pkg::NPORTS,
   parameter int DATA_W = switch_pkg::DATA_W
);
   localparam int PORT_W = $clog2(NPORTS);

   logic [NPORTS-1:0]        in_valid;
   logic [NPORTS*DATA_W-1:0] in_data;
   logic [NPORTS-1:0]        in_ready;
   logic [NPORTS-1:0]        out_valid;
   logic [NPORTS*DATA_W-1:0] out_data;
   logic [NPORTS-1:0]        out_busy;
   logic [NPORTS*PORT_W-1:0] out_owner;
   logic [31:0]              stall_count;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_busy,
      input  out_owner,
      input  stall_count
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      output out_busy,
      output out_owner,
      output stall_count
   );

endinterface

// File: rtl/switch_port_arbiter_rr_arbiter.sv
// Single-output round-robin picker: first requester at or above ptr_i, wrapping.
// Purely combinational; NPORTS must be a power of two so the index wraps for free.
module rr_arbiter #(
   parameter int NPORTS = switch_pkg::NPORTS
) (
   input  logic [NPORTS-1:0]         req_i,
   input  logic [$clog2(NPORTS)-1:0] ptr_i,
   output logic [NPORTS-1:0]         gnt_o,
   output logic [$clog2(NPORTS)-1:0] gnt_idx_o,
   output logic                      any_gnt_o
);
   localparam int PORT_W = $clog2(NPORTS);

   logic [PORT_W-1:0] idx;

   // Walk offsets from farthest to nearest so the nearest requester wins last.
   always_comb begin
      idx       = '0;
      gnt_idx_o = '0;
      any_gnt_o = 1'b0;
      for (int k = NPORTS - 1; k >= 0; k--) begin
         idx = ptr_i + PORT_W'(k);
         if (req_i[idx]) begin
            gnt_idx_o = idx;
            any_gnt_o = 1'b1;
         end
      end
   end

   always_comb begin
      gnt_o = '0;
      if (any_gnt_o) begin
         gnt_o[gnt_idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/switch_port_arbiter.sv
// Output-port arbiter: locks each output to one input from header to EOP, round-robin per output.
// Forwarded words appear one cycle after acceptance; losers see in_ready=0 and hold their word.
module switch_port_arbiter #(
   parameter int NPORTS = switch_pkg::NPORTS,
   parameter int DATA_W = switch_pkg::DATA_W
) (
   input  logic                 clk,
   input  logic                 reset,
   switch_port_arbiter_if.slave bus
);
   import switch_pkg::*;

   localparam int PORT_W = $clog2(NPORTS);

   logic [NPORTS-1:0][DATA_W-1:0] word;
   logic [NPORTS-1:0]             is_eop;
   logic [NPORTS-1:0]             rdy;
   logic                          stalled;

   logic [NPORTS-1:0][NPORTS-1:0] req;
   logic [NPORTS-1:0][NPORTS-1:0] gnt;
   logic [NPORTS-1:0][PORT_W-1:0] gnt_idx;
   logic [NPORTS-1:0]             any_gnt;
   logic [NPORTS-1:0][NPORTS-1:0] lock_hit;
   logic [NPORTS-1:0][NPORTS-1:0] sel;

   in_state_t                     in_state_q [NPORTS];
   in_state_t                     in_state_d [NPORTS];
   logic [NPORTS-1:0][PORT_W-1:0] in_dest_q, in_dest_d;

   out_state_t                    out_state_q [NPORTS];
   out_state_t                    out_state_d [NPORTS];
   logic [NPORTS-1:0][PORT_W-1:0] out_owner_q, out_owner_d;
   logic [NPORTS-1:0][PORT_W-1:0] rr_ptr_q, rr_ptr_d;

   logic [NPORTS-1:0]             out_valid_q, out_valid_d;
   logic [NPORTS-1:0][DATA_W-1:0] out_data_q, out_data_d;
   logic [31:0]                   stall_q, stall_d;

   always_comb begin
      for (int i = 0; i < NPORTS; i++) begin
         word[i]   = bus.in_data[i*DATA_W +: DATA_W];
         is_eop[i] = (word[i] == DATA_W'(EOP_WORD));
      end
   end

   // Only idle inputs compete, and only for outputs that are currently free.
   always_comb begin
      req = '0;
      for (int o = 0; o < NPORTS; o++) begin
         for (int i = 0; i < NPORTS; i++) begin
            req[o][i] = bus.in_valid[i]
                        && (in_state_q[i] == IN_IDLE)
                        && (word[i][PORT_W-1:0] == PORT_W'(o))
                        && (out_state_q[o] == OUT_FREE);
         end
      end
   end

   for (genvar o = 0; o < NPORTS; o++) begin : g_arb
      rr_arbiter #(
         .NPORTS (NPORTS)
      ) u_rr_arbiter (
         .req_i     (req[o]),
         .ptr_i     (rr_ptr_q[o]),
         .gnt_o     (gnt[o]),
         .gnt_idx_o (gnt_idx[o]),
         .any_gnt_o (any_gnt[o])
      );
   end

   always_comb begin
      lock_hit = '0;
      for (int o = 0; o < NPORTS; o++) begin
         for (int i = 0; i < NPORTS; i++) begin
            lock_hit[o][i] = bus.in_valid[i]
                             && (in_state_q[i] == IN_LOCKED)
                             && (in_dest_q[i] == PORT_W'(o));
         end
      end
   end

   always_comb begin
      rdy = '0;
      for (int i = 0; i < NPORTS; i++) begin
         rdy[i] = bus.in_valid[i] && (in_state_q[i] == IN_LOCKED);
      end
      for (int o = 0; o < NPORTS; o++) begin
         rdy = rdy | gnt[o];
      end
   end

   assign stalled = |(bus.in_valid & ~rdy);

   // Each output has at most one selected source, so an AND-OR mux suffices.
   always_comb begin
      out_valid_d = '0;
      out_data_d  = out_data_q;
      sel         = '0;
      for (int o = 0; o < NPORTS; o++) begin
         sel[o]         = gnt[o] | lock_hit[o];
         out_valid_d[o] = |sel[o];
         if (out_valid_d[o]) begin
            out_data_d[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
               out_data_d[o] = out_data_d[o] | (word[i] & {DATA_W{sel[o][i]}});
            end
         end
      end
   end

   // Grants touch only FREE outputs / IDLE inputs and releases only BUSY / LOCKED, so they never collide.
   always_comb begin
      in_state_d  = in_state_q;
      in_dest_d   = in_dest_q;
      out_state_d = out_state_q;
      out_owner_d = out_owner_q;
      rr_ptr_d    = rr_ptr_q;
      for (int o = 0; o < NPORTS; o++) begin
         if (any_gnt[o]) begin
            rr_ptr_d[o] = gnt_idx[o] + PORT_W'(1);
            if (!is_eop[gnt_idx[o]]) begin
               out_state_d[o]          = OUT_BUSY;
               out_owner_d[o]          = gnt_idx[o];
               in_state_d[gnt_idx[o]]  = IN_LOCKED;
               in_dest_d[gnt_idx[o]]   = PORT_W'(o);
            end
         end
      end
      for (int i = 0; i < NPORTS; i++) begin
         if ((in_state_q[i] == IN_LOCKED) && bus.in_valid[i] && is_eop[i]) begin
            in_state_d[i]               = IN_IDLE;
            out_state_d[in_dest_q[i]]   = OUT_FREE;
            out_owner_d[in_dest_q[i]]   = '0;
         end
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (stalled && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NPORTS; i++) begin
            in_state_q[i]  <= IN_IDLE;
            out_state_q[i] <= OUT_FREE;
         end
         in_dest_q   <= '0;
         out_owner_q <= '0;
         rr_ptr_q    <= '0;
         out_valid_q <= '0;
         out_data_q  <= '0;
         stall_q     <= '0;
      end else begin
         in_state_q  <= in_state_d;
         out_state_q <= out_state_d;
         in_dest_q   <= in_dest_d;
         out_owner_q <= out_owner_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         stall_q     <= stall_d;
      end
   end

   always_comb begin
      bus.in_ready    = rdy;
      bus.out_valid   = out_valid_q;
      bus.stall_count = stall_q;
      bus.out_data    = '0;
      bus.out_busy    = '0;
      bus.out_owner   = '0;
      for (int o = 0; o < NPORTS; o++) begin
         bus.out_data[o*DATA_W +: DATA_W]  = out_data_q[o];
         bus.out_busy[o]                   = (out_state_q[o] == OUT_BUSY);
         bus.out_owner[o*PORT_W +: PORT_W] = out_owner_q[o];
      end
   end

endmodule

// File: tb/tb_switch_port_arbiter.sv
// Scoreboard bench for switch_port_arbiter: per-output expected-word queues plus directed timing checks.
module tb_switch_port_arbiter;
   import switch_pkg::*;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   switch_port_arbiter_if #(.NPORTS(4), .DATA_W(32)) bus();

   switch_port_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   word_t srcq [4][$];
   word_t sbq  [4][$];

   int n_vec = 0;
   int n_err = 0;

   logic [3:0]   ov, rdy_s, busy_s;
   logic [7:0]   owner_s;
   logic [31:0]  stall_s;
   logic [127:0] data_s;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   task automatic drive();
      logic [3:0]   v;
      logic [127:0] d;
      v = '0;
      d = '0;
      for (int i = 0; i < 4; i++) begin
         if (srcq[i].size() != 0) begin
            v[i]          = 1'b1;
            d[i*32 +: 32] = srcq[i][0];
         end
      end
      bus.in_valid = v;
      bus.in_data  = d;
   endtask

   // Sample one cycle at the falling edge, score forwarded words, then advance past the rising edge.
   task automatic step();
      logic [3:0] acc;
      logic       rst_s;
      word_t      exp_w;
      @(negedge clk);
      ov      = bus.out_valid;
      rdy_s   = bus.in_ready;
      busy_s  = bus.out_busy;
      owner_s = bus.out_owner;
      stall_s = bus.stall_count;
      data_s  = bus.out_data;
      rst_s   = reset;
      acc     = bus.in_valid & bus.in_ready;
      for (int o = 0; o < 4; o++) begin
         if (ov[o]) begin
            if (sbq[o].size() == 0) begin
               chk($sformatf("sb_extra_o%0d", o), 64'(data_s[o*32 +: 32]), 64'h1_0000_0000);
            end else begin
               exp_w = sbq[o].pop_front();
               chk($sformatf("sb_data_o%0d", o), 64'(data_s[o*32 +: 32]), 64'(exp_w));
            end
         end
      end
      @(posedge clk);
      #1;
      if (!rst_s) begin
         for (int i = 0; i < 4; i++) begin
            if (acc[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
         end
      end
      drive();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic send(input int src, input int dst, input word_t w0, input word_t w1,
                       input word_t w2, input int n);
      word_t w [3];
      w[0] = w0;
      w[1] = w1;
      w[2] = w2;
      for (int k = 0; k < n; k++) begin
         srcq[src].push_back(w[k]);
         sbq[dst].push_back(w[k]);
      end
   endtask

   task automatic do_reset();
      for (int i = 0; i < 4; i++) begin
         srcq[i].delete();
         sbq[i].delete();
      end
      reset = 1'b1;
      drive();
      run(2);
      reset = 1'b0;
   endtask

   task automatic drain_chk(input string tag);
      run(5);
      for (int o = 0; o < 4; o++) begin
         chk($sformatf("%s_left_o%0d", tag, o), 64'(sbq[o].size()), 64'd0);
      end
   endtask

   initial begin
      reset        = 1'b1;
      bus.in_valid = '0;
      bus.in_data  = '0;
      @(posedge clk);
      #1;
      do_reset();

      // Reset state
      step();
      chk("rst_valid", 64'(ov), 64'h0);
      chk("rst_busy", 64'(busy_s), 64'h0);
      chk("rst_owner", 64'(owner_s), 64'h0);
      chk("rst_stall", 64'(stall_s), 64'h0);
      chk("rst_data", 64'(data_s[63:0] | data_s[127:64]), 64'h0);

      // Single packet, input 1 -> port 2
      do_reset();
      send(1, 2, 32'h0000_0102, 32'hAAAA_0000, 32'h0, 3);
      drive();
      step();
      chk("t1_hdr_rdy", 64'(rdy_s[1]), 64'h1);
      chk("t1_pre_valid", 64'(ov[2]), 64'h0);
      step();
      chk("t1_v0", 64'(ov[2]), 64'h1);
      chk("t1_busy0", 64'(busy_s[2]), 64'h1);
      chk("t1_owner", 64'(owner_s[5:4]), 64'h1);
      step();
      chk("t1_v1", 64'(ov[2]), 64'h1);
      chk("t1_busy1", 64'(busy_s[2]), 64'h1);
      step();
      chk("t1_v2", 64'(ov[2]), 64'h1);
      chk("t1_busy_rel", 64'(busy_s[2]), 64'h0);
      chk("t1_owner_rel", 64'(owner_s[5:4]), 64'h0);
      step();
      chk("t1_v3", 64'(ov[2]), 64'h0);
      chk("t1_stall", 64'(stall_s), 64'h0);
      drain_chk("t1");

      // Collision on port 1 between inputs 0 and 3
      do_reset();
      send(0, 1, 32'h0000_0101, 32'h1111_0000, 32'h0, 3);
      send(3, 1, 32'h0000_0301, 32'h3333_0000, 32'h0, 3);
      drive();
      step();
      chk("t2_rdy0", 64'(rdy_s[0]), 64'h1);
      chk("t2_blk_c0", 64'(rdy_s[3]), 64'h0);
      step();
      chk("t2_blk_c1", 64'(rdy_s[3]), 64'h0);
      step();
      chk("t2_blk_c2", 64'(rdy_s[3]), 64'h0);
      step();
      chk("t2_gnt3", 64'(rdy_s[3]), 64'h1);
      chk("t2_stall", 64'(stall_s), 64'd3);
      drain_chk("t2");

      // Round-robin fairness on port 0
      do_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) begin
            send(i, 0, 32'h0000_1000 | word_t'(i << 8) | word_t'(k << 4), 32'h0, 32'h0, 2);
         end
      end
      // Expected order is 0,1,2,3,0,1,2,3, not the per-input enqueue order above.
      sbq[0].delete();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) begin
            sbq[0].push_back(32'h0000_1000 | word_t'(i << 8) | word_t'(k << 4));
            sbq[0].push_back(32'h0);
         end
      end
      drive();
      run(20);
      drain_chk("t3");

      // Parallel flows, all four outputs at once
      do_reset();
      send(0, 3, 32'h0000_0A03, 32'hA0A0_0001, 32'h0, 3);
      send(1, 2, 32'h0000_0B02, 32'hB0B0_0001, 32'h0, 3);
      send(2, 1, 32'h0000_0C01, 32'hC0C0_0001, 32'h0, 3);
      send(3, 0, 32'h0000_0D00, 32'hD0D0_0001, 32'h0, 3);
      drive();
      step();
      chk("t4_rdy_all", 64'(rdy_s), 64'hF);
      step();
      chk("t4_valid_all", 64'(ov), 64'hF);
      chk("t4_busy_all", 64'(busy_s), 64'hF);
      chk("t4_owner", 64'(owner_s), 64'h1B);
      drain_chk("t4");
      chk("t4_stall", 64'(stall_s), 64'h0);

      // Zero-word packet from input 2, then pointer check on port 0
      do_reset();
      send(2, 0, 32'h0, 32'h0, 32'h0, 1);
      drive();
      step();
      chk("t5_rdy2", 64'(rdy_s[2]), 64'h1);
      send(3, 0, 32'h0000_0F00, 32'h0, 32'h0, 2);
      send(0, 0, 32'h0000_0E00, 32'h0, 32'h0, 2);
      drive();
      step();
      chk("t5_pulse", 64'(ov[0]), 64'h1);
      chk("t5_not_busy", 64'(busy_s[0]), 64'h0);
      chk("t5_ptr_in3", 64'(rdy_s[3]), 64'h1);
      chk("t5_ptr_in0", 64'(rdy_s[0]), 64'h0);
      drain_chk("t5");

      // Reset while input 0 owns port 2
      do_reset();
      srcq[0].push_back(32'h0000_0502);
      srcq[0].push_back(32'h5555_0000);
      srcq[0].push_back(32'h5555_0001);
      srcq[0].push_back(32'h0);
      sbq[2].push_back(32'h0000_0502);
      sbq[2].push_back(32'h5555_0000);
      srcq[3].push_back(32'h0000_0702);
      drive();
      step();
      chk("t6_rdy0", 64'(rdy_s[0]), 64'h1);
      chk("t6_blk3", 64'(rdy_s[3]), 64'h0);
      step();
      reset = 1'b1;
      srcq[0].delete();
      srcq[3].delete();
      drive();
      step();
      chk("t6_pre_stall", 64'(stall_s), 64'd2);
      chk("t6_pre_busy", 64'(busy_s[2]), 64'h1);
      reset = 1'b0;
      send(1, 2, 32'h0000_0602, 32'h0, 32'h0, 2);
      drive();
      step();
      chk("t6_valid", 64'(ov), 64'h0);
      chk("t6_busy", 64'(busy_s), 64'h0);
      chk("t6_stall", 64'(stall_s), 64'h0);
      chk("t6_new_gnt", 64'(rdy_s[1]), 64'h1);
      drain_chk("t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
